// File: rtl/ysyx_23060229_ifu_if.sv
// ysyx_23060229_ifu_if: fetch-side bundle carrying the imem request/response, instruction handoff, redirect and fault signals
interface ysyx_23060229_ifu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;
    logic                  imem_rsp_err;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  fetch_err;
    logic [ADDR_WIDTH-1:0] fetch_err_pc;
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_pc,
        output fetch_err, fetch_err_pc
    );
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_pc,
        input  fetch_err, fetch_err_pc
    );
endinterface

// File: rtl/ysyx_23060229_ifu.sv
// ysyx_23060229_ifu: single-outstanding instruction fetch with redirect kill and sticky fault
module ysyx_23060229_ifu #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic                 clk,
    input logic                 rst,
    ysyx_23060229_ifu_if.master bus
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;
    state_t                state;
    logic [ADDR_WIDTH-1:0] pc, req_addr, inst_pc_q, err_pc_q, target;
    logic [DATA_WIDTH-1:0] inst_q;
    logic                  kill, err_q, redir, rsp, bad;
    // target is where fetch resumes: a redirect this cycle wins over the stored pc
    always_comb begin
        redir  = bus.redirect_valid;
        rsp    = bus.imem_rsp_valid;
        target = redir ? bus.redirect_pc : pc;
        bad    = target[1:0] != 2'b00;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            kill      <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            err_q     <= 1'b0;
            err_pc_q  <= '0;
        end else begin
            if (redir) begin
                pc    <= bus.redirect_pc;
                err_q <= bad;
                if (bad) err_pc_q <= bus.redirect_pc;
            end
            case (state)
                S_REQ: begin
                    kill <= kill || redir;
                    if (bus.imem_req_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (rsp && (kill || redir)) begin
                        kill     <= 1'b0;
                        req_addr <= target;
                        state    <= bad ? S_ERR : S_REQ;
                    end else if (rsp && bus.imem_rsp_err) begin
                        err_q    <= 1'b1;
                        err_pc_q <= req_addr;
                        state    <= S_ERR;
                    end else if (rsp) begin
                        inst_q    <= bus.imem_rsp_data;
                        inst_pc_q <= req_addr;
                        pc        <= req_addr + ADDR_WIDTH'(4);
                        state     <= S_HOLD;
                    end else if (redir) begin
                        kill <= 1'b1;
                    end
                end
                default: begin
                    if (redir || (state == S_HOLD && bus.inst_ready)) begin
                        req_addr <= target;
                        state    <= bad ? S_ERR : S_REQ;
                    end
                end
            endcase
        end
    end
    assign bus.imem_req_valid = state == S_REQ && !rst;
    assign bus.imem_req_addr  = req_addr;
    assign bus.inst_valid     = state == S_HOLD;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.fetch_err      = err_q;
    assign bus.fetch_err_pc   = err_pc_q;
endmodule

// File: tb/tb_ysyx_23060229_ifu.sv
// tb_ysyx_23060229_ifu: directed fetch scenarios against a bench memory, with request and instruction scoreboards
module tb_ysyx_23060229_ifu;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } inst_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int mem_lat = 0;
    logic [31:0] err_addr = 32'h8;
    logic [31:0] req_q[$];
    inst_t exp_inst[$];
    ysyx_23060229_ifu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b ();
    ysyx_23060229_ifu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );
    always #5 clk = ~clk;
    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a << 8) | 32'h13;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_hold(input string tag);
        int n = 0;
        @(negedge clk);
        while (!b.inst_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(b.inst_valid), 32'd1);
    endtask
    task automatic wait_taken(input string tag);
        int n = 0;
        @(negedge clk);
        while (!(b.imem_req_valid && b.imem_req_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(b.imem_req_valid && b.imem_req_ready), 32'd1);
        tick();
    endtask
    task automatic consume();
        tick();
        b.inst_ready = 1'b1;
        tick();
        b.inst_ready = 1'b0;
    endtask
    task automatic redirect(input logic [31:0] t, input logic rdy);
        tick();
        b.redirect_valid = 1'b1;
        b.redirect_pc    = t;
        b.inst_ready     = rdy;
        tick();
        b.redirect_valid = 1'b0;
        b.inst_ready     = 1'b0;
    endtask
    // memory: takes a request at a posedge, answers mem_lat cycles later with a one-cycle pulse
    initial begin : mem
        logic take;
        logic [31:0] a, pa;
        int pend;
        pend = -1;
        pa = '0;
        b.imem_rsp_valid = 1'b0;
        b.imem_rsp_data  = '0;
        b.imem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            take = b.imem_req_valid && b.imem_req_ready;
            a = b.imem_req_addr;
            tick();
            b.imem_rsp_valid = 1'b0;
            if (take) begin
                checks++;
                assert (req_q.size() != 0) else begin
                    errors++;
                    $error("FAIL req_unexpected observed=%h expected=none", a);
                end
                if (req_q.size() != 0) chk("req_addr", a, req_q.pop_front());
                pa = a;
                pend = mem_lat;
            end
            if (pend == 0) begin
                b.imem_rsp_valid = 1'b1;
                b.imem_rsp_data  = data_of(pa);
                b.imem_rsp_err   = pa == err_addr;
                pend = -1;
            end else if (pend > 0) begin
                pend--;
            end
        end
    end
    initial begin : mon
        inst_t e;
        forever begin
            @(negedge clk);
            if (!rst && b.inst_valid && b.inst_ready) begin
                checks++;
                assert (exp_inst.size() != 0) else begin
                    errors++;
                    $error("FAIL inst_unexpected observed=%h expected=none", b.inst_pc);
                end
                if (exp_inst.size() != 0) begin
                    e = exp_inst.pop_front();
                    chk("cons_pc", b.inst_pc, e.pc);
                    chk("cons_inst", b.inst, e.data);
                end
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end
    initial begin
        b.imem_req_ready = 1'b1;
        b.inst_ready     = 1'b0;
        b.redirect_valid = 1'b0;
        b.redirect_pc    = '0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_req_valid", 32'(b.imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(b.inst_valid), 32'd0);
        chk("rst_inst", b.inst, 32'h0);
        chk("rst_inst_pc", b.inst_pc, 32'h0);
        chk("rst_fetch_err", 32'(b.fetch_err), 32'd0);
        chk("rst_fetch_err_pc", b.fetch_err_pc, 32'h0);
        req_q.push_back(32'h0);
        exp_inst.push_back('{pc: 32'h0, data: 32'h13});
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t1_req_valid", 32'(b.imem_req_valid), 32'd1);
        chk("t1_req_addr", b.imem_req_addr, 32'h0);
        chk("t1_req_inst_valid", 32'(b.inst_valid), 32'd0);
        @(negedge clk);
        chk("t1_wait_inst_valid", 32'(b.inst_valid), 32'd0);
        @(negedge clk);
        chk("t1_inst_valid", 32'(b.inst_valid), 32'd1);
        chk("t1_inst", b.inst, 32'h13);
        chk("t1_inst_pc", b.inst_pc, 32'h0);
        repeat (5) begin
            @(negedge clk);
            chk("t2_stall_valid", 32'(b.inst_valid), 32'd1);
            chk("t2_stall_inst", b.inst, 32'h13);
            chk("t2_stall_pc", b.inst_pc, 32'h0);
            chk("t2_stall_req_valid", 32'(b.imem_req_valid), 32'd0);
        end
        req_q.push_back(32'h4);
        exp_inst.push_back('{pc: 32'h4, data: data_of(32'h4)});
        consume();
        @(negedge clk);
        chk("t2_req_valid", 32'(b.imem_req_valid), 32'd1);
        chk("t2_req_addr", b.imem_req_addr, 32'h4);
        wait_hold("t2_hold");
        chk("t2_inst_pc", b.inst_pc, 32'h4);
        mem_lat = 3;
        req_q.push_back(32'h8);
        consume();
        wait_taken("t3_taken");
        mem_lat = 0;
        req_q.push_back(32'h100);
        redirect(32'h100, 1'b0);
        wait_hold("t3_hold");
        chk("t3_inst_pc", b.inst_pc, 32'h100);
        chk("t3_inst", b.inst, data_of(32'h100));
        exp_inst.push_back('{pc: 32'h100, data: data_of(32'h100)});
        req_q.push_back(32'h8);
        redirect(32'h8, 1'b1);
        @(negedge clk);
        chk("t4_drop_valid", 32'(b.inst_valid), 32'd0);
        chk("t4_req_addr", b.imem_req_addr, 32'h8);
        repeat (3) @(negedge clk);
        chk("t4_err", 32'(b.fetch_err), 32'd1);
        chk("t4_err_pc", b.fetch_err_pc, 32'h8);
        chk("t4_err_req_valid", 32'(b.imem_req_valid), 32'd0);
        chk("t4_err_inst_valid", 32'(b.inst_valid), 32'd0);
        req_q.push_back(32'h20);
        redirect(32'h20, 1'b0);
        @(negedge clk);
        chk("t4_err_clear", 32'(b.fetch_err), 32'd0);
        chk("t4_req_valid", 32'(b.imem_req_valid), 32'd1);
        chk("t4_req_addr_20", b.imem_req_addr, 32'h20);
        wait_hold("t4_hold");
        chk("t4_inst_pc", b.inst_pc, 32'h20);
        chk("t4_inst", b.inst, data_of(32'h20));
        redirect(32'h102, 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk("t5_err", 32'(b.fetch_err), 32'd1);
            chk("t5_err_pc", b.fetch_err_pc, 32'h102);
            chk("t5_req_valid", 32'(b.imem_req_valid), 32'd0);
            chk("t5_inst_valid", 32'(b.inst_valid), 32'd0);
        end
        req_q.push_back(32'hFFFFFFFC);
        redirect(32'hFFFFFFFC, 1'b0);
        wait_hold("t6_hold");
        chk("t6_inst_pc", b.inst_pc, 32'hFFFFFFFC);
        chk("t6_inst", b.inst, data_of(32'hFFFFFFFC));
        chk("t6_err_clear", 32'(b.fetch_err), 32'd0);
        exp_inst.push_back('{pc: 32'hFFFFFFFC, data: data_of(32'hFFFFFFFC)});
        req_q.push_back(32'h0);
        mem_lat = 3;
        consume();
        @(negedge clk);
        chk("t6_wrap_req_valid", 32'(b.imem_req_valid), 32'd1);
        chk("t6_wrap_req_addr", b.imem_req_addr, 32'h0);
        tick();
        rst = 1'b1;
        mem_lat = 0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_rst_req_valid", 32'(b.imem_req_valid), 32'd0);
        chk("t6_rst_inst_valid", 32'(b.inst_valid), 32'd0);
        chk("t6_rst_inst", b.inst, 32'h0);
        chk("t6_rst_inst_pc", b.inst_pc, 32'h0);
        chk("t6_rst_fetch_err", 32'(b.fetch_err), 32'd0);
        chk("t6_rst_fetch_err_pc", b.fetch_err_pc, 32'h0);
        tick();
        rst = 1'b0;
        req_q.push_back(32'h0);
        @(negedge clk);
        chk("t6_post_req_valid", 32'(b.imem_req_valid), 32'd1);
        chk("t6_post_req_addr", b.imem_req_addr, 32'h0);
        chk("t6_post_inst_valid", 32'(b.inst_valid), 32'd0);
        @(negedge clk);
        chk("t6_stale_ignored", 32'(b.inst_valid), 32'd0);
        @(negedge clk);
        chk("t6_refetch_valid", 32'(b.inst_valid), 32'd1);
        chk("t6_refetch_pc", b.inst_pc, 32'h0);
        chk("t6_refetch_inst", b.inst, 32'h13);
        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        chk("inst_q_empty", 32'(exp_inst.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
